lab3_sweep: RTL and testbench

Synthesizable truth-table sweeper that sits directly upstream of the lab3 dataflow gate block. It drives the gate block's `x`/`y` inputs through every input combination in counting order and samples its `q1`/`q2`/`q3` outputs for each one. It then presents the complete response table for display on board LEDs. It replaces the simulation-only stimulus loop with a start/busy/done handshake that runs on hardware.

---
 rtl/lab3_sweep.sv | 136 +++++++++++++
 tb/tb_lab3_sweep.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab3_sweep.sv
// lab3_sweep: truth-table sweeper for the lab3 gate block.
// Steps the stimulus vector through every input combination in counting
// order, holds each one for HOLD_CYCLES cycles, samples the gate response
// on the last cycle of the hold, and keeps the full response table on
// its output for display. `table` is a reserved word in SystemVerilog, so
// the captured table is exposed as resp_table.
module lab3_sweep #(
  parameter int N_IN        = 2,
  parameter int N_OUT       = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_OUT-1:0]             resp,
  output logic [N_IN-1:0]              vec,
  output logic [N_IN-1:0]              idx,
  output logic                         busy,
  output logic                         done,
  output logic [(2**N_IN)*N_OUT-1:0]   resp_table
);

  localparam int DEPTH   = 2 ** N_IN;
  localparam int TBL_W   = DEPTH * N_OUT;
  localparam int TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [N_IN-1:0]    IDX_LAST   = '1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [N_IN-1:0]      vec_q,   vec_d;
  logic [N_IN-1:0]      idx_q,   idx_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;
  logic [TBL_W-1:0]     table_q, table_d;

  // Next-state logic: start handshake, hold timer, sample and advance.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    busy_d  = busy_q;
    done_d  = done_q;
    table_d = table_q;

    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        // The table is only cleared when a new sweep is accepted, so a
        // finished table stays on the LEDs indefinitely.
        if (start) begin
          state_d = S_RUN;
          table_d = '0;
          idx_d   = '0;
          vec_d   = '0;
          timer_d = '0;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        if (timer_q != TIMER_LAST) begin
          timer_d = timer_q + 1'b1;
        end else begin
          // Last cycle of the hold: resp has had HOLD_CYCLES-1 full
          // cycles to settle since vec changed.
          for (int i = 0; i < DEPTH; i++) begin
            if (idx_q == N_IN'(i)) begin
              table_d[i*N_OUT +: N_OUT] = resp;
            end
          end
          timer_d = '0;
          if (idx_q == IDX_LAST) begin
            // Stop on the last index; idx/vec never wrap.
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            vec_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
            vec_d = idx_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        // One-cycle done pulse; start is not queued here.
        state_d = S_IDLE;
        done_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        vec_d   = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
    end
  end

  assign vec        = vec_q;
  assign idx        = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign resp_table = table_q;

endmodule

// File: tb/tb_lab3_sweep.sv
// Bench for lab3_sweep: default sweeper (a), N_IN=3/HOLD=3 sweeper (b),
// and HOLD=2 sweeper fed by a two-cycle-late gate model (c).
module tb_lab3_sweep;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic logic [2:0] gate(input logic x, input logic y);
    return {x & y, x | y, x ^ y};
  endfunction

  // ---------------- instance a: defaults ----------------
  logic        start_a = 1'b0;
  logic [2:0]  resp_a;
  logic [1:0]  vec_a, idx_a;
  logic        busy_a, done_a;
  logic [11:0] table_a;
  int          mode_a = 0;          // 0 = live model, 1 = 2-cycle late, 2 = forced
  logic [2:0]  force_a = 3'b000;
  logic [2:0]  dly_a1 = 3'b000, dly_a2 = 3'b000;

  always @(posedge clk) begin
    dly_a1 <= gate(vec_a[1], vec_a[0]);
    dly_a2 <= dly_a1;
  end

  always_comb begin
    resp_a = gate(vec_a[1], vec_a[0]);
    if (mode_a == 1) resp_a = dly_a2;
    else if (mode_a == 2) resp_a = force_a;
  end

  lab3_sweep #(.N_IN(2), .N_OUT(3), .HOLD_CYCLES(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .resp(resp_a),
    .vec(vec_a), .idx(idx_a), .busy(busy_a), .done(done_a),
    .resp_table(table_a)
  );

  // ---------------- instance b: N_IN=3, HOLD=3 ----------------
  logic        start_b = 1'b0;
  logic [2:0]  resp_b;
  logic [2:0]  vec_b, idx_b;
  logic        busy_b, done_b;
  logic [23:0] table_b;

  assign resp_b = gate(vec_b[2], vec_b[0]);

  lab3_sweep #(.N_IN(3), .N_OUT(3), .HOLD_CYCLES(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .resp(resp_b),
    .vec(vec_b), .idx(idx_b), .busy(busy_b), .done(done_b),
    .resp_table(table_b)
  );

  // ---------------- instance c: HOLD=2, late resp ----------------
  logic        start_c = 1'b0;
  logic [2:0]  resp_c;
  logic [1:0]  vec_c, idx_c;
  logic        busy_c, done_c;
  logic [11:0] table_c;
  logic [2:0]  dly_c1 = 3'b000, dly_c2 = 3'b000;

  always @(posedge clk) begin
    dly_c1 <= gate(vec_c[1], vec_c[0]);
    dly_c2 <= dly_c1;
  end
  assign resp_c = dly_c2;

  lab3_sweep #(.N_IN(2), .N_OUT(3), .HOLD_CYCLES(2)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .resp(resp_c),
    .vec(vec_c), .idx(idx_c), .busy(busy_c), .done(done_c),
    .resp_table(table_c)
  );

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start on instance a and wait (bounded) for the done pulse,
  // then one more edge so the sweeper is back in IDLE.
  task automatic run_sweep_a(input string name);
    int n;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, 64'(done_a), 64'd1);
    tick();
  endtask

  typedef struct {
    logic       start;
    logic [1:0] vec;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tv[18];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   rise_at[3];
    int   nrise, ndone, nbusy;
    logic prev_busy;
    logic done_seen;
    logic [23:0] exp_b;

    // Basic sweep vectors: vec 0,1,2,3 held 4 cycles each, done at E16.
    tv[0]  = '{1'b1, 2'd0, 1'b1, 1'b0};
    tv[1]  = '{1'b0, 2'd0, 1'b1, 1'b0};
    tv[2]  = '{1'b0, 2'd0, 1'b1, 1'b0};
    tv[3]  = '{1'b0, 2'd0, 1'b1, 1'b0};
    tv[4]  = '{1'b0, 2'd1, 1'b1, 1'b0};
    tv[5]  = '{1'b0, 2'd1, 1'b1, 1'b0};
    tv[6]  = '{1'b0, 2'd1, 1'b1, 1'b0};
    tv[7]  = '{1'b0, 2'd1, 1'b1, 1'b0};
    tv[8]  = '{1'b0, 2'd2, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 2'd2, 1'b1, 1'b0};
    tv[10] = '{1'b0, 2'd2, 1'b1, 1'b0};
    tv[11] = '{1'b0, 2'd2, 1'b1, 1'b0};
    tv[12] = '{1'b0, 2'd3, 1'b1, 1'b0};
    tv[13] = '{1'b0, 2'd3, 1'b1, 1'b0};
    tv[14] = '{1'b0, 2'd3, 1'b1, 1'b0};
    tv[15] = '{1'b0, 2'd3, 1'b1, 1'b0};
    tv[16] = '{1'b0, 2'd0, 1'b0, 1'b1};
    tv[17] = '{1'b0, 2'd0, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_vec",   64'(vec_a),   64'd0);
    chk("rst_idx",   64'(idx_a),   64'd0);
    chk("rst_busy",  64'(busy_a),  64'd0);
    chk("rst_done",  64'(done_a),  64'd0);
    chk("rst_table", 64'(table_a), 64'd0);
    rst = 1'b0;
    tick();

    // Basic sweep, table-driven
    for (int k = 0; k < 18; k++) begin
      start_a = tv[k].start;
      tick();
      chk($sformatf("basic_vec_%0d", k),  64'(vec_a),  64'(tv[k].vec));
      chk($sformatf("basic_busy_%0d", k), 64'(busy_a), 64'(tv[k].busy));
      chk($sformatf("basic_done_%0d", k), 64'(done_a), 64'(tv[k].done));
      if (k < 16) chk($sformatf("basic_idx_%0d", k), 64'(idx_a), 64'(tv[k].vec));
      if (k == 0) chk("basic_table_cleared", 64'(table_a), 64'd0);
    end
    chk("basic_table", 64'(table_a), 64'hCD8);

    // Held start: sweeps accepted at E0, E18 (and E36), start ignored otherwise
    rise_at = '{-1, -1, -1};
    nrise = 0;
    ndone = 0;
    prev_busy = busy_a;
    start_a = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (busy_a && !prev_busy && nrise < 3) begin
        rise_at[nrise] = c;
        nrise++;
      end
      if (done_a) begin
        ndone++;
        chk($sformatf("held_table_%0d", c), 64'(table_a), 64'hCD8);
      end
      prev_busy = busy_a;
    end
    start_a = 1'b0;
    chk("held_rise0", 64'(rise_at[0]), 64'd0);
    chk("held_rise1", 64'(rise_at[1]), 64'd18);
    chk("held_ndone", 64'(ndone), 64'd2);
    for (int n = 0; n < 40 && (busy_a || done_a); n++) tick();
    chk("held_drain_busy", 64'(busy_a), 64'd0);
    chk("held_final_table", 64'(table_a), 64'hCD8);

    // Late-settling resp (2-cycle delay) with HOLD=4
    mode_a = 1;
    tick();
    tick();
    run_sweep_a("late");
    chk("late_table", 64'(table_a), 64'hCD8);
    mode_a = 0;

    // Table retention with arbitrary resp, then clear at next start
    mode_a = 2;
    for (int n = 0; n < 20; n++) begin
      force_a = 3'($urandom_range(0, 7));
      tick();
    end
    chk("retain_table", 64'(table_a), 64'hCD8);
    chk("retain_busy",  64'(busy_a),  64'd0);
    mode_a = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("retain_cleared", 64'(table_a), 64'd0);
    for (int n = 0; n < 40 && !done_a; n++) tick();
    chk("retain_refill", 64'(table_a), 64'hCD8);
    tick();

    // Reset mid-sweep at E7 (forced resp so entry 0 is non-zero)
    mode_a = 2;
    force_a = 3'b111;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (7) tick();
    chk("midrst_pre_table", 64'(table_a), 64'h007);
    chk("midrst_pre_vec",   64'(vec_a),   64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy",  64'(busy_a),  64'd0);
    chk("midrst_vec",   64'(vec_a),   64'd0);
    chk("midrst_idx",   64'(idx_a),   64'd0);
    chk("midrst_table", 64'(table_a), 64'd0);
    #3;
    rst = 1'b0;
    mode_a = 0;
    done_seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (done_a || busy_a) done_seen = 1'b1;
    end
    chk("midrst_no_activity", 64'(done_seen), 64'd0);
    run_sweep_a("postrst");
    chk("postrst_table", 64'(table_a), 64'hCD8);

    // Parameter check: N_IN=3, HOLD=3
    exp_b = '0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] iv;
      iv = 3'(i);
      exp_b[i*3 +: 3] = gate(iv[2], iv[0]);
    end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    nbusy = busy_b ? 1 : 0;
    chk("p3_vec_0", 64'(vec_b), 64'd0);
    for (int k = 1; k < 30; k++) begin
      tick();
      if (busy_b) nbusy++;
      if (k < 24) chk($sformatf("p3_vec_%0d", k), 64'(vec_b), 64'(k / 3));
    end
    chk("p3_busy_len", 64'(nbusy), 64'd24);
    chk("p3_table", 64'(table_b), 64'(exp_b));

    // HOLD=2 with the same late model captures the wrong table
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int n = 0; n < 40 && !done_c; n++) tick();
    chk("hold2_done", 64'(done_c), 64'd1);
    chk("hold2_table", 64'(table_c), 64'h6C0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
